updown_cnt_ctrl: RTL and testbench

//  Sequencer for the 4-bit up/down count register on the board top level.
//  - Generates the count-enable strobe and direction.
//  - Debounces raw pushbuttons for run/pause, direction and clear.
//  - Applies the wrap, saturate or bounce limit policy.
//  The counter register, LED bar decode and seven-segment driver stay downstream;

---
 rtl/udc_pkg.sv | 23 ++
 rtl/updown_cnt_ctrl_if.sv | 17 +
 rtl/udc_debounce.sv | 54 +++++
 rtl/updown_cnt_ctrl.sv | 166 ++++++++++++++++
 tb/tb_updown_cnt_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udc_pkg.sv
// Shared constants for the up/down count sequencer.
//  - state_t: FSM encoding, also driven out on the 2-bit state port.
//  - M_*:     limit-policy encodings of the mode input (2'b11 acts as wrap).
//  - B_*:     bit positions of the raw buttons in the debouncer bank.
package udc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LIMIT = 2'd3
    } state_t;

    localparam logic [1:0] M_WRAP   = 2'b00;
    localparam logic [1:0] M_SAT    = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;

    localparam int B_RUN  = 0;
    localparam int B_DIR  = 1;
    localparam int B_CLR  = 2;
    localparam int B_STEP = 3;

endpackage

// File: rtl/updown_cnt_ctrl_if.sv
// Control link between the sequencer and the downstream count register.
//  cnt_val  present counter value (counter -> sequencer)
//  cnt_en   one-clk step strobe   (sequencer -> counter)
//  cnt_up   step direction, 1 = increment
//  cnt_clr  one-clk synchronous clear
// Modports: master = sequencer side, slave = counter side.
interface updown_cnt_ctrl_if #(
    parameter int CNT_W = 4
);
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_en;
    logic             cnt_up;
    logic             cnt_clr;

    modport master (input cnt_val, output cnt_en, output cnt_up, output cnt_clr);
    modport slave  (output cnt_val, input cnt_en, input cnt_up, input cnt_clr);
endinterface

// File: rtl/udc_debounce.sv
// Pushbutton debouncer: 2-flop synchroniser followed by a stability counter.
// The debounced level follows the synchronised input once it has differed from
// the current level for DB_CYCLES consecutive samples; press is a one-clk pulse
// issued together with a rising level change.
// Ports:
//  clk    in   clock
//  clr_n  in   asynchronous active-low reset
//  raw    in   raw button, asynchronous
//  level  out  debounced level
//  press  out  one-clk pulse on the debounced rising edge
module udc_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] stab_reg;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            stab_reg  <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                // Any sample equal to the accepted level restarts the run.
                stab_reg <= '0;
            end else if (stab_reg == CW'(DB_CYCLES - 1)) begin
                stab_reg  <= '0;
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;
            end else begin
                stab_reg <= stab_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;
endmodule

// File: rtl/updown_cnt_ctrl.sv
// Sequencer for the up/down count register: debounces run/dir/clear buttons,
// generates the count-enable strobe and direction, and applies the wrap,
// saturate or bounce limit policy. The counter itself lives downstream.
// Optional feature macro: UDC_STEP_EN adds btn_step (single step while paused).
// Ports:
//  clk       in   clock
//  clr_n     in   asynchronous active-low reset
//  btn_run   in   raw run/pause button
//  btn_dir   in   raw direction switch, 1 = up
//  btn_clr   in   raw clear button
//  btn_step  in   raw single-step button (UDC_STEP_EN only)
//  mode      in   00 wrap, 01 saturate, 10 bounce, 11 wrap
//  ctr       master side of the counter link (cnt_val in; cnt_en/cnt_up/cnt_clr out)
//  state     out  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LIMIT
module updown_cnt_ctrl
    import udc_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int TICK_DIV  = 25_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     btn_run,
    input  logic                     btn_dir,
    input  logic                     btn_clr,
`ifdef UDC_STEP_EN
    input  logic                     btn_step,
`endif
    input  logic [1:0]               mode,
    updown_cnt_ctrl_if.master        ctr,
    output logic [1:0]               state
);
`ifdef UDC_STEP_EN
    localparam int N_BTN = 4;
`else
    localparam int N_BTN = 3;
`endif
    localparam int PW = $clog2(TICK_DIV);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;

    assign btn_raw[B_RUN] = btn_run;
    assign btn_raw[B_DIR] = btn_dir;
    assign btn_raw[B_CLR] = btn_clr;
`ifdef UDC_STEP_EN
    assign btn_raw[B_STEP] = btn_step;
`endif

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
        udc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .clr_n (clr_n),
            .raw   (btn_raw[gi]),
            .level (btn_level[gi]),
            .press (btn_press[gi])
        );
    end

    // Debouncer outputs this block has no use for.
    logic unused_db;
`ifdef UDC_STEP_EN
    assign unused_db = ^{btn_level[B_RUN], btn_level[B_CLR], btn_press[B_DIR], btn_level[B_STEP]};
`else
    assign unused_db = ^{btn_level[B_RUN], btn_level[B_CLR], btn_press[B_DIR]};
`endif

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          cnt_en_reg, cnt_en_next;
    logic          cnt_up_reg, cnt_up_next;
    logic          cnt_clr_reg, cnt_clr_next;
    logic          bounce_reg, bounce_next;

    logic tick, dir_eff, cnt_max, cnt_zero, hit_cur, sat_block, bounce_flip, step_up;

    assign tick     = (state_reg == S_RUN) && (presc_reg == PW'(TICK_DIV - 1));
    assign dir_eff  = (mode == M_BOUNCE) ? bounce_reg : btn_level[B_DIR];
    assign cnt_max  = (ctr.cnt_val == {CNT_W{1'b1}});
    assign cnt_zero = (ctr.cnt_val == {CNT_W{1'b0}});
    // Counter already sits at the end it is heading towards.
    assign hit_cur     = dir_eff ? cnt_max : cnt_zero;
    assign sat_block   = (mode == M_SAT) && hit_cur;
    // Bounce reverses inside the same strobe, so the end value is never repeated.
    assign bounce_flip = (mode == M_BOUNCE) && hit_cur;
    assign step_up     = bounce_flip ? ~dir_eff : dir_eff;

    always_comb begin
        state_next   = state_reg;
        cnt_en_next  = 1'b0;
        cnt_up_next  = cnt_up_reg;
        cnt_clr_next = 1'b0;
        bounce_next  = bounce_reg;
        if (btn_press[B_CLR]) begin
            state_next   = S_IDLE;
            cnt_clr_next = 1'b1;
            bounce_next  = 1'b1;
        end else if (btn_press[B_RUN]) begin
            case (state_reg)
                S_RUN, S_LIMIT: state_next = S_PAUSE;
                default:        state_next = S_RUN;
            endcase
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (tick) begin
                        if (sat_block) begin
                            state_next = S_LIMIT;
                        end else begin
                            cnt_en_next = 1'b1;
                            cnt_up_next = step_up;
                            if (bounce_flip) bounce_next = ~bounce_reg;
                        end
                    end
                end
                // Leave LIMIT once the direction points away from the end, or
                // once saturate is no longer selected and the new policy can act.
                S_LIMIT: begin
                    if ((mode != M_SAT) || !hit_cur) state_next = S_RUN;
                end
`ifdef UDC_STEP_EN
                S_PAUSE: begin
                    if (btn_press[B_STEP] && !sat_block) begin
                        cnt_en_next = 1'b1;
                        cnt_up_next = step_up;
                        if (bounce_flip) bounce_next = ~bounce_reg;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Prescaler only advances while staying in RUN; any entry to RUN starts at 0.
    always_comb begin
        presc_next = '0;
        if ((state_reg == S_RUN) && (state_next == S_RUN) && !tick)
            presc_next = presc_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg   <= S_IDLE;
            presc_reg   <= '0;
            cnt_en_reg  <= 1'b0;
            cnt_up_reg  <= 1'b0;
            cnt_clr_reg <= 1'b0;
            bounce_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            cnt_en_reg  <= cnt_en_next;
            cnt_up_reg  <= cnt_up_next;
            cnt_clr_reg <= cnt_clr_next;
            bounce_reg  <= bounce_next;
        end
    end

    assign ctr.cnt_en  = cnt_en_reg;
    assign ctr.cnt_up  = cnt_up_reg;
    assign ctr.cnt_clr = cnt_clr_reg;
    assign state       = state_reg;
endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// Bench for updown_cnt_ctrl with TICK_DIV=4, DB_CYCLES=3. A behavioural 4-bit
// counter closes the loop on cnt_val. Stimulus pushes the expected strobes
// (direction, counter value at the strobe, spacing in clks) into a queue; a
// monitor pops one entry for every cnt_en/cnt_clr it sees.
// A button raised right after a strobe takes effect 6 clks later, so exactly
// one further strobe (4 clks later) is still expected before it acts.
module tb_updown_cnt_ctrl;

    typedef struct {
        bit is_clr;
        bit up;
        int val;
        int gap;
    } exp_t;

    logic       clk;
    logic       clr_n;
    logic       btn_run, btn_dir, btn_clr;
`ifdef UDC_STEP_EN
    logic       btn_step;
`endif
    logic [1:0] mode;
    logic [1:0] state;
    logic [3:0] cnt_model;
    logic       load_req;
    logic [3:0] load_val;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_en = 0;
    int   n_seen = 0;
    exp_t exp_q[$];

    updown_cnt_ctrl_if #(.CNT_W(4)) bus ();

    updown_cnt_ctrl #(.CNT_W(4), .TICK_DIV(4), .DB_CYCLES(3)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .btn_run  (btn_run),
        .btn_dir  (btn_dir),
        .btn_clr  (btn_clr),
`ifdef UDC_STEP_EN
        .btn_step (btn_step),
`endif
        .mode     (mode),
        .ctr      (bus),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog");
    end

    // Downstream count register model.
    always @(posedge clk) begin
        if (load_req)          cnt_model <= load_val;
        else if (bus.cnt_clr)  cnt_model <= 4'd0;
        else if (bus.cnt_en)   cnt_model <= bus.cnt_up ? cnt_model + 4'd1 : cnt_model - 4'd1;
    end
    assign bus.cnt_val = cnt_model;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        cyc = cyc + 1;
        if (clr_n && (bus.cnt_en || bus.cnt_clr)) begin
            checks = checks + 1;
            n_seen = n_seen + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_strobe: act en=%0b clr=%0b up=%0b val=%0d req none",
                         bus.cnt_en, bus.cnt_clr, bus.cnt_up, bus.cnt_val);
            end else begin
                e = exp_q.pop_front();
                if (e.is_clr)
                    ok = bus.cnt_clr && !bus.cnt_en;
                else
                    ok = bus.cnt_en && !bus.cnt_clr && (bus.cnt_up == e.up) &&
                         (int'(bus.cnt_val) == e.val) && (e.gap == 0 || cyc - last_en == e.gap);
                if (!ok) begin
                    errors = errors + 1;
                    $display("FAIL strobe_%0d: act en=%0b clr=%0b up=%0b val=%0d gap=%0d req clr=%0b up=%0b val=%0d gap=%0d",
                             n_seen, bus.cnt_en, bus.cnt_clr, bus.cnt_up, bus.cnt_val, cyc - last_en,
                             e.is_clr, e.up, e.val, e.gap);
                end else begin
                    $display("strobe %0d: en=%0b clr=%0b up=%0b val=%0d", n_seen,
                             bus.cnt_en, bus.cnt_clr, bus.cnt_up, bus.cnt_val);
                end
            end
            if (bus.cnt_en) last_en = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: act=%0d req=%0d", name, act, req);
        end else begin
            $display("check %s: %0d", name, act);
        end
    endtask

    task automatic push_en(input int val, input bit up, input int gap);
        exp_t e;
        e.is_clr = 1'b0;
        e.up     = up;
        e.val    = val;
        e.gap    = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_clr();
        exp_t e;
        e.is_clr = 1'b1;
        e.up     = 1'b0;
        e.val    = 0;
        e.gap    = 0;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: act pending=%0d req pending=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_run = v;
            1: btn_dir = v;
            2: btn_clr = v;
`ifdef UDC_STEP_EN
            3: btn_step = v;
`endif
            default: ;
        endcase
    endtask

    // Raise a raw button for 'hold' clks, release, and let the release debounce.
    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        load_val = v;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        #1;
    endtask

    initial begin
        clr_n    = 1'b0;
        btn_run  = 1'b0;
        btn_dir  = 1'b0;
        btn_clr  = 1'b0;
`ifdef UDC_STEP_EN
        btn_step = 1'b0;
`endif
        mode     = 2'b00;
        load_req = 1'b0;
        load_val = 4'd0;
        @(negedge clk);
        load(4'd0);
        wait_cycles(2);
        chk("reset_state", int'(state), 0);
        chk("reset_cnt_en", int'(bus.cnt_en), 0);
        chk("reset_cnt_up", int'(bus.cnt_up), 0);
        chk("reset_cnt_clr", int'(bus.cnt_clr), 0);
        clr_n = 1'b1;

        // 1. Wrap mode counting up through 15 -> 0.
        btn_dir = 1'b1;
        wait_cycles(10);
        chk("idle_after_release", int'(state), 0);
        for (int i = 0; i < 31; i++) push_en(i % 16, 1'b1, (i == 0) ? 0 : 4);
        press(0, 5);
        chk("run_entered", int'(state), 1);
        wait_empty("wrap");

        // 2. Saturate: stops at 15 in LIMIT, then leaves when direction flips.
        mode = 2'b01;
        wait_cycles(8);
        chk("sat_limit_state", int'(state), 3);
        chk("sat_limit_value", int'(cnt_model), 15);
        push_en(15, 1'b0, 0);
        btn_dir = 1'b0;
        wait_empty("sat_leave");
        chk("sat_back_to_run", int'(state), 1);

        // 3. Bounce from 14 with the direction register still 1.
        mode = 2'b10;
        push_en(14, 1'b1, 4);
        push_en(15, 1'b0, 4);
        for (int v = 14; v >= 1; v--) push_en(v, 1'b0, 4);
        push_en(0, 1'b1, 4);
        push_en(1, 1'b1, 4);
        wait_empty("bounce");

        // 5a. clr and run together in RUN: one more strobe, then only the clear.
        push_en(2, 1'b1, 4);
        push_clr();
        btn_clr = 1'b1;
        btn_run = 1'b1;
        repeat (5) @(negedge clk);
        btn_clr = 1'b0;
        btn_run = 1'b0;
        wait_cycles(8);
        wait_empty("clr");
        chk("clr_state_idle", int'(state), 0);
        chk("clr_value", int'(cnt_model), 0);

        // 4. Glitch ignored; held press toggles RUN/PAUSE exactly once.
        press(0, 2);
        wait_cycles(4);
        chk("glitch_idle", int'(state), 0);
        mode = 2'b00;
        push_en(0, 1'b0, 0);
        push_en(15, 1'b0, 4);
        press(0, 5);
        wait_empty("down_run");
        push_en(14, 1'b0, 4);
        press(0, 5);
        wait_cycles(16);
        chk("pause_state", int'(state), 2);
        chk("pause_value", int'(cnt_model), 13);
        press(0, 2);
        wait_cycles(4);
        chk("glitch_pause", int'(state), 2);

        // 5b. Asynchronous reset mid-prescale while counting up.
        btn_dir = 1'b1;
        wait_cycles(10);
        push_en(13, 1'b1, 0);
        press(0, 5);
        wait_empty("resume");
        @(negedge clk);
        chk("pre_reset_up", int'(bus.cnt_up), 1);
        clr_n = 1'b0;
        #1;
        chk("async_cnt_en", int'(bus.cnt_en), 0);
        chk("async_cnt_up", int'(bus.cnt_up), 0);
        chk("async_cnt_clr", int'(bus.cnt_clr), 0);
        chk("async_state", int'(state), 0);
        wait_cycles(3);
        clr_n = 1'b1;
        wait_cycles(12);
        chk("post_reset_idle", int'(state), 0);
        chk("post_reset_value", int'(cnt_model), 14);

`ifdef UDC_STEP_EN
        // 6. Single step in PAUSE; ignored in RUN and LIMIT.
        mode = 2'b01;
        load(4'd15);
        press(0, 5);
        wait_cycles(4);
        chk("step_limit", int'(state), 3);
        press(0, 5);
        chk("step_pause", int'(state), 2);
        btn_dir = 1'b0;
        wait_cycles(8);
        load(4'd5);
        push_en(5, 1'b0, 0);
        press(3, 5);
        wait_empty("step1");
        push_en(4, 1'b0, 0);
        press(3, 5);
        wait_empty("step2");
        chk("step_value", int'(cnt_model), 3);
        chk("step_still_pause", int'(state), 2);
        load(4'd0);
        press(3, 5);
        wait_cycles(6);
        chk("step_sat_pause", int'(state), 2);
        chk("step_sat_value", int'(cnt_model), 0);
        load(4'd2);
        push_en(2, 1'b0, 0);
        push_en(1, 1'b0, 4);
        press(0, 5);
        press(3, 5);
        wait_empty("step_in_run");
        wait_cycles(8);
        chk("step_run_limit", int'(state), 3);
        chk("step_run_value", int'(cnt_model), 0);
`endif

        wait_cycles(10);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
